// File: rtl/code_prefetch_loader.sv
// Block-buffered command loader: caches one block of commands tagged by IP, refilled over the data fabric on a miss.
// Optional miss counter output MISS_CNT is built when CODE_LOADER_MISS_CNT_EN is defined.
module code_prefetch_loader #(
    parameter int         CMD_W      = 16,
    parameter int         DATA_W     = 8,
    parameter int         SEG_W      = 8,
    parameter int         DEPTH_LOG2 = 3,
    parameter logic [3:0] UNIT_ID    = 4'd1
) (
    input  logic              CLK_B,
    input  logic              RESET,
    input  logic              CLK_C,
    input  logic [SEG_W-1:0]  IP,
    input  logic              FLUSH,
    output logic [CMD_W-1:0]  COMMAND,
    output logic              CMD_VALID,
    output logic              STALL,
    output logic              REQUEST,
    input  logic              EN,
    output logic [3:0]        NUMBER_UNIT,
    output logic              ADDRFD,
    output logic [SEG_W-1:0]  FD_ADDR,
    output logic              READFD,
    input  logic [DATA_W-1:0] FD_DATA,
    input  logic              BUSY_SLAVE
`ifdef CODE_LOADER_MISS_CNT_EN
    ,
    output logic [15:0]       MISS_CNT
`endif
);

    localparam int BEATS  = CMD_W / DATA_W;
    localparam int DEPTH  = 2 ** DEPTH_LOG2;
    localparam int TAG_W  = SEG_W - DEPTH_LOG2;
    localparam int LANE_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [LANE_W-1:0]     LANE_LAST = LANE_W'(BEATS - 1);
    localparam logic [DEPTH_LOG2-1:0] IDX_LAST  = '1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_REQ  = 3'd1;
    localparam logic [2:0] S_ADDR = 3'd2;
    localparam logic [2:0] S_READ = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]            state;
    logic                  clkc_d;
    logic                  front_c;
    logic [SEG_W-1:0]      ip_q;
    logic                  tag_valid;
    logic                  flush_pend;
    logic [TAG_W-1:0]      fill_tag;
    logic [TAG_W-1:0]      stored_tag;
    logic [TAG_W-1:0]      tag;
    logic [DEPTH_LOG2-1:0] idx;
    logic                  hit;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [LANE_W-1:0]     wr_lane;
    logic                  beat_xfer;
    logic                  last_beat;
    logic [CMD_W-1:0]      cmd_buf [DEPTH];

    assign front_c   = CLK_C & ~clkc_d;
    assign tag       = ip_q[SEG_W-1:DEPTH_LOG2];
    assign idx       = ip_q[DEPTH_LOG2-1:0];
    assign hit       = tag_valid && (tag == stored_tag);
    assign beat_xfer = (state == S_READ) && EN && !BUSY_SLAVE;
    assign last_beat = (wr_idx == IDX_LAST) && (wr_lane == LANE_LAST);

    // Outputs decode straight from state so an asynchronous reset drops them at once
    assign CMD_VALID   = hit && (state == S_IDLE);
    assign STALL       = ~CMD_VALID;
    assign COMMAND     = CMD_VALID ? cmd_buf[idx] : '0;
    assign REQUEST     = (state == S_REQ) || (state == S_ADDR) || (state == S_READ);
    assign NUMBER_UNIT = REQUEST ? UNIT_ID : 4'd0;
    assign ADDRFD      = (state == S_ADDR);
    assign FD_ADDR     = ADDRFD ? {fill_tag, {DEPTH_LOG2{1'b0}}} : '0;
    assign READFD      = (state == S_READ);

    always_ff @(posedge CLK_B or negedge RESET) begin
        if (!RESET) begin
            state      <= S_IDLE;
            clkc_d     <= 1'b0;
            ip_q       <= '0;
            tag_valid  <= 1'b0;
            flush_pend <= 1'b0;
        end else begin
            clkc_d <= CLK_C;
            if (front_c)
                ip_q <= IP;
            if (FLUSH && state != S_IDLE)
                flush_pend <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (FLUSH)
                        tag_valid <= 1'b0;
                    if (!hit) begin
                        state     <= S_REQ;
                        tag_valid <= 1'b0;
                    end
                end
                S_REQ:
                    if (EN)
                        state <= S_ADDR;
                S_ADDR:
                    if (!EN) begin
                        state      <= S_IDLE;
                        flush_pend <= 1'b0;
                    end else begin
                        state <= S_READ;
                    end
                S_READ:
                    if (!EN) begin
                        state      <= S_IDLE;
                        flush_pend <= 1'b0;
                    end else if (!BUSY_SLAVE && last_beat) begin
                        state <= S_DONE;
                    end
                S_DONE: begin
                    // A flush seen anywhere during the fill leaves the block invalid
                    tag_valid  <= !(flush_pend || FLUSH);
                    flush_pend <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_B) begin
        if (state == S_IDLE && !hit)
            fill_tag <= tag;
        if (state == S_DONE)
            stored_tag <= fill_tag;
        if (state == S_ADDR) begin
            wr_idx  <= '0;
            wr_lane <= '0;
        end else if (beat_xfer) begin
            cmd_buf[wr_idx][wr_lane*DATA_W +: DATA_W] <= FD_DATA;
            if (wr_lane == LANE_LAST) begin
                wr_lane <= '0;
                wr_idx  <= wr_idx + 1'b1;
            end else begin
                wr_lane <= wr_lane + 1'b1;
            end
        end
    end

`ifdef CODE_LOADER_MISS_CNT_EN
    always_ff @(posedge CLK_B or negedge RESET) begin
        if (!RESET)
            MISS_CNT <= '0;
        else if (state == S_IDLE && !hit && MISS_CNT != 16'hFFFF)
            MISS_CNT <= MISS_CNT + 16'd1;
    end
`endif

endmodule

// File: tb/tb_code_prefetch_loader.sv
// Directed bench for code_prefetch_loader: fabric data for beat k of a fill is seed+k.
module tb_code_prefetch_loader;

    logic        CLK_B = 1'b0;
    logic        RESET = 1'b0;
    logic        CLK_C = 1'b0;
    logic [7:0]  IP = 8'h00;
    logic        FLUSH = 1'b0;
    logic [15:0] COMMAND;
    logic        CMD_VALID;
    logic        STALL;
    logic        REQUEST;
    logic        EN = 1'b1;
    logic [3:0]  NUMBER_UNIT;
    logic        ADDRFD;
    logic [7:0]  FD_ADDR;
    logic        READFD;
    logic [7:0]  FD_DATA = 8'h00;
    logic        BUSY_SLAVE = 1'b0;
`ifdef CODE_LOADER_MISS_CNT_EN
    logic [15:0] MISS_CNT;
`endif

    code_prefetch_loader dut (
        .CLK_B(CLK_B), .RESET(RESET), .CLK_C(CLK_C), .IP(IP), .FLUSH(FLUSH),
        .COMMAND(COMMAND), .CMD_VALID(CMD_VALID), .STALL(STALL), .REQUEST(REQUEST),
        .EN(EN), .NUMBER_UNIT(NUMBER_UNIT), .ADDRFD(ADDRFD), .FD_ADDR(FD_ADDR),
        .READFD(READFD), .FD_DATA(FD_DATA), .BUSY_SLAVE(BUSY_SLAVE)
`ifdef CODE_LOADER_MISS_CNT_EN
        , .MISS_CNT(MISS_CNT)
`endif
    );

    always #5 CLK_B = ~CLK_B;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] seed     = 8'h00;
    int         beat_k   = 0;
    int         n_addr   = 0;
    int         n_req    = 0;
    int         n_rd     = 0;
    logic [7:0] last_addr = 8'h00;
    bit         prev_req = 0;
    bit         busy_alt = 0;
    bit         cv_seen  = 0;

    // One bus cycle; also plays the fabric slave and records bus events
    task automatic tick();
        bit xfer;
        xfer = READFD && EN && !BUSY_SLAVE;
        @(posedge CLK_B);
        #1;
        if (xfer) beat_k++;
        if (ADDRFD) begin
            beat_k    = 0;
            n_addr++;
            last_addr = FD_ADDR;
        end
        if (READFD) n_rd++;
        if (REQUEST && !prev_req) n_req++;
        prev_req = REQUEST;
        if (CMD_VALID) cv_seen = 1;
        if (busy_alt) BUSY_SLAVE = !BUSY_SLAVE;
        FD_DATA = seed + 8'(beat_k);
    endtask

    task automatic core_edge(input logic [7:0] ip);
        tick();
        CLK_C = 1'b1;
        IP    = ip;
        tick();
        CLK_C = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int n);
        n = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (CMD_VALID) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_beat(input int k, input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (READFD && beat_k == k) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        repeat (3) tick();
        n_checks++; if (REQUEST !== 1'b0) begin n_fail++; $display("FAIL reset_request: got %b want 0", REQUEST); end
        n_checks++; if (CMD_VALID !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %b want 0", CMD_VALID); end
        n_checks++; if (READFD !== 1'b0 || ADDRFD !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got readfd=%b addrfd=%b want 0 0", READFD, ADDRFD); end
        n_checks++; if (COMMAND !== 16'h0000) begin n_fail++; $display("FAIL reset_command: got %h want 0000", COMMAND); end
        n_checks++; if (NUMBER_UNIT !== 4'h0 || FD_ADDR !== 8'h00) begin n_fail++; $display("FAIL reset_unit_addr: got %h %h want 0 00", NUMBER_UNIT, FD_ADDR); end
`ifdef CODE_LOADER_MISS_CNT_EN
        n_checks++; if (MISS_CNT !== 16'h0000) begin n_fail++; $display("FAIL reset_miss_cnt: got %h want 0000", MISS_CNT); end
`endif
    endtask

    task automatic test_cold_start();
        int n;
        seed    = 8'h10;
        FD_DATA = seed;
        n_rd    = 0;
        RESET   = 1'b1;
        tick();
        n_checks++; if (REQUEST !== 1'b1 || NUMBER_UNIT !== 4'd1) begin n_fail++; $display("FAIL cold_request: got req=%b unit=%h want 1 1", REQUEST, NUMBER_UNIT); end
        tick();
        n_checks++; if (ADDRFD !== 1'b1 || FD_ADDR !== 8'h00) begin n_fail++; $display("FAIL cold_addr: got addrfd=%b addr=%h want 1 00", ADDRFD, FD_ADDR); end
        wait_valid(40, n);
        n_checks++; if (n !== 18) begin n_fail++; $display("FAIL cold_latency: got %0d want 18 after addr", n); end
        n_checks++; if (n_rd !== 16 || beat_k !== 16) begin n_fail++; $display("FAIL cold_beats: got readfd=%0d xfer=%0d want 16 16", n_rd, beat_k); end
        n_checks++; if (COMMAND !== 16'h1110 || STALL !== 1'b0) begin n_fail++; $display("FAIL cold_command: got %h stall=%b want 1110 0", COMMAND, STALL); end
    endtask

    task automatic test_hit_path();
        int         req0;
        logic [15:0] exp;
        req0 = n_req;
        for (int i = 1; i < 8; i++) begin
            core_edge(8'(i));
            exp = {seed + 8'(2 * i + 1), seed + 8'(2 * i)};
            n_checks++;
            if (CMD_VALID !== 1'b1 || COMMAND !== exp) begin
                n_fail++; $display("FAIL hit_ip%0d: got valid=%b cmd=%h want 1 %h", i, CMD_VALID, COMMAND, exp);
            end
        end
        n_checks++; if (n_req !== req0) begin n_fail++; $display("FAIL hit_no_request: got %0d requests want %0d", n_req, req0); end
    endtask

    task automatic test_block_crossing();
        int n;
        seed = 8'h40;
        core_edge(8'h08);
        n_checks++; if (STALL !== 1'b1) begin n_fail++; $display("FAIL cross_stall: got %b want 1", STALL); end
        wait_valid(40, n);
        n_checks++; if (n !== 20) begin n_fail++; $display("FAIL cross_latency: got %0d want 20", n); end
        n_checks++; if (last_addr !== 8'h08) begin n_fail++; $display("FAIL cross_fd_addr: got %h want 08", last_addr); end
        n_checks++; if (COMMAND !== 16'h4140) begin n_fail++; $display("FAIL cross_cmd0: got %h want 4140", COMMAND); end
        core_edge(8'h0B);
        n_checks++; if (COMMAND !== 16'h4746) begin n_fail++; $display("FAIL cross_cmd3: got %h want 4746", COMMAND); end
    endtask

    task automatic test_backpressure();
        int n;
        int bad;
        int addr0;
        seed  = 8'h80;
        EN    = 1'b0;
        core_edge(8'h10);
        addr0 = n_addr;
        bad   = 0;
        repeat (5) begin
            tick();
            if (REQUEST !== 1'b1 || ADDRFD !== 1'b0) bad++;
        end
        n_checks++; if (bad !== 0 || n_addr !== addr0) begin n_fail++; $display("FAIL bp_hold_request: got %0d bad cycles %0d addr pulses want 0 0", bad, n_addr - addr0); end
        EN         = 1'b1;
        busy_alt   = 1;
        BUSY_SLAVE = 1'b1;
        wait_valid(80, n);
        busy_alt   = 0;
        BUSY_SLAVE = 1'b0;
        n_checks++; if (n < 0) begin n_fail++; $display("FAIL bp_timeout: got no CMD_VALID want valid within 80"); end
        n_checks++; if (beat_k !== 16 || last_addr !== 8'h10) begin n_fail++; $display("FAIL bp_beats_addr: got %0d %h want 16 10", beat_k, last_addr); end
        n_checks++; if (COMMAND !== 16'h8180) begin n_fail++; $display("FAIL bp_cmd0: got %h want 8180", COMMAND); end
        core_edge(8'h17);
        n_checks++; if (COMMAND !== 16'h8F8E) begin n_fail++; $display("FAIL bp_cmd7: got %h want 8f8e", COMMAND); end
    endtask

    task automatic test_flush_mid_read();
        int n;
        int addr0;
        int req0;
        bit ok;
        seed  = 8'hC0;
        addr0 = n_addr;
        req0  = n_req;
        core_edge(8'h18);
        wait_beat(7, 60, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL flush_reach_beat7: got timeout want beat 7"); end
        cv_seen = 0;
        FLUSH   = 1'b1;
        tick();
        FLUSH   = 1'b0;
        for (int i = 0; i < 60 && n_addr < addr0 + 2; i++) tick();
        n_checks++; if (n_addr !== addr0 + 2) begin n_fail++; $display("FAIL flush_refetch: got %0d addr pulses want 2", n_addr - addr0); end
        n_checks++; if (cv_seen !== 1'b0) begin n_fail++; $display("FAIL flush_valid_suppressed: got valid=1 want 0"); end
        n_checks++; if (last_addr !== 8'h18 || n_req !== req0 + 2) begin n_fail++; $display("FAIL flush_addr_req: got %h %0d want 18 2", last_addr, n_req - req0); end
        wait_valid(40, n);
        n_checks++; if (n < 0 || COMMAND !== 16'hC1C0) begin n_fail++; $display("FAIL flush_cmd0: got n=%0d cmd=%h want C1C0", n, COMMAND); end
    endtask

    task automatic test_en_drop();
        int n;
        int addr0;
        bit ok;
        seed  = 8'hE0;
        addr0 = n_addr;
        core_edge(8'h20);
        wait_beat(3, 60, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_reach_beat3: got timeout want beat 3"); end
        EN = 1'b0;
        tick();
        n_checks++; if (REQUEST !== 1'b0 || READFD !== 1'b0 || ADDRFD !== 1'b0 || CMD_VALID !== 1'b0) begin
            n_fail++; $display("FAIL abort_outputs: got req=%b rd=%b addr=%b valid=%b want 0 0 0 0", REQUEST, READFD, ADDRFD, CMD_VALID);
        end
        EN = 1'b1;
        tick();
        n_checks++; if (REQUEST !== 1'b1) begin n_fail++; $display("FAIL abort_rerequest: got %b want 1", REQUEST); end
        wait_valid(40, n);
        n_checks++; if (n !== 19) begin n_fail++; $display("FAIL abort_latency: got %0d want 19", n); end
        n_checks++; if (n_addr !== addr0 + 2 || last_addr !== 8'h20 || COMMAND !== 16'hE1E0) begin
            n_fail++; $display("FAIL abort_refill: got pulses=%0d addr=%h cmd=%h want 2 20 E1E0", n_addr - addr0, last_addr, COMMAND);
        end
    endtask

    task automatic test_reset_mid_fill();
        int n;
        bit ok;
        seed = 8'h30;
        core_edge(8'h28);
        wait_beat(5, 60, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL rst_reach_beat5: got timeout want beat 5"); end
        #2 RESET = 1'b0;
        #1;
        n_checks++; if (REQUEST !== 1'b0 || READFD !== 1'b0 || CMD_VALID !== 1'b0) begin
            n_fail++; $display("FAIL rst_async_outputs: got req=%b rd=%b valid=%b want 0 0 0", REQUEST, READFD, CMD_VALID);
        end
`ifdef CODE_LOADER_MISS_CNT_EN
        n_checks++; if (MISS_CNT !== 16'h0000) begin n_fail++; $display("FAIL rst_miss_cnt_clear: got %h want 0000", MISS_CNT); end
`endif
        tick();
        RESET = 1'b1;
        tick();
        n_checks++; if (REQUEST !== 1'b1) begin n_fail++; $display("FAIL rst_rerequest: got %b want 1", REQUEST); end
`ifdef CODE_LOADER_MISS_CNT_EN
        n_checks++; if (MISS_CNT !== 16'h0001) begin n_fail++; $display("FAIL rst_miss_cnt_one: got %h want 0001", MISS_CNT); end
`endif
        wait_valid(40, n);
        n_checks++; if (n !== 19 || COMMAND !== 16'h3130) begin n_fail++; $display("FAIL rst_refill: got n=%0d cmd=%h want 19 3130", n, COMMAND); end
    endtask

    task automatic test_flush_idle();
        int n;
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        n_checks++; if (CMD_VALID !== 1'b0) begin n_fail++; $display("FAIL idle_flush_invalidate: got %b want 0", CMD_VALID); end
        wait_valid(40, n);
        n_checks++; if (n !== 20 || COMMAND !== 16'h3130) begin n_fail++; $display("FAIL idle_flush_refill: got n=%0d cmd=%h want 20 3130", n, COMMAND); end
    endtask

    initial begin
        test_reset();
        test_cold_start();
        test_hit_path();
        test_block_crossing();
        test_backpressure();
        test_flush_mid_read();
        test_en_drop();
        test_reset_mid_fill();
        test_flush_idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/code_prefetch_loader.md
Name: code_prefetch_loader

Overview:
- Parametrised command loader between the core and the data fabric.
- Holds one block of 2**DEPTH_LOG2 commands in a local buffer, tagged by the upper bits of IP.
- On a miss it arbitrates for the fabric via REQUEST/EN, then burst-reads the block beat by beat.
- Runs on the bus clock CLK_B; samples the core clock CLK_C as a rising-edge event.

Parameters:
CMD_W, 16, command width in bits; must be an integer multiple of DATA_W.
DATA_W, 8, fabric data beat width.
SEG_W, 8, IP/segment address width.
DEPTH_LOG2, 3, log2 of commands per buffered block; 1 <= DEPTH_LOG2 < SEG_W.
UNIT_ID, 4'd1, value driven on NUMBER_UNIT while requesting.

Ports:
CLK_B  in  1  bus clock; all state on its rising edge.
RESET  in  1  asynchronous, active-low.
CLK_C  in  1  core clock, sampled on CLK_B.
IP  in  SEG_W  core instruction pointer.
FLUSH  in  1  one-cycle pulse; invalidates the buffer.
COMMAND  out  CMD_W  command at the latched IP.
CMD_VALID  out  1  COMMAND is valid for the latched IP.
STALL  out  1  equals !CMD_VALID.
REQUEST  out  1  fabric ownership request.
EN  in  1  fabric grant.
NUMBER_UNIT  out  4  requesting unit ID.
ADDRFD  out  1  address strobe.
FD_ADDR  out  SEG_W  block base command address.
READFD  out  1  read beat strobe.
FD_DATA  in  DATA_W  fabric read data.
BUSY_SLAVE  in  1  slave not ready.

Behaviour:
- Reset values: all outputs 0; tag_valid=0; IP_q=0; state=IDLE; buffer contents don't-care.
- Edge detect: clkc_d <= CLK_C each CLK_B. front_C = CLK_C & !clkc_d. On front_C, IP_q <= IP.
- Derived signals:
  - BEATS = CMD_W/DATA_W per command.
  - Fill length N = 2**DEPTH_LOG2 * BEATS beats.
  - tag = IP_q[SEG_W-1:DEPTH_LOG2].
  - idx = IP_q[DEPTH_LOG2-1:0].
  - hit = tag_valid && tag == stored_tag.
- Outputs:
  - CMD_VALID = hit && state==IDLE (combinational).
  - COMMAND = buf[idx] when CMD_VALID, else 0.
- FSM:
  - IDLE: if !hit, go to REQ, latch fill_tag <= tag, clear tag_valid.
  - REQ: REQUEST=1, NUMBER_UNIT=UNIT_ID. Hold until EN=1, then go to ADDR.
  - ADDR: one cycle. ADDRFD=1, FD_ADDR={fill_tag, DEPTH_LOG2'b0}. Go to READ.
  - READ: READFD=1. A beat transfers in any cycle with BUSY_SLAVE=0.
    - Beat k is written to buf[k/BEATS] bits [(k%BEATS)*DATA_W +: DATA_W] (little-endian).
    - The beat counter advances only on a transfer.
    - After beat N-1, go to DONE.
  - DONE: one cycle. REQUEST=0, stored_tag <= fill_tag, tag_valid <= !flush_pend. Go to IDLE.
- REQUEST stays high continuously from REQ through the last READ cycle. NUMBER_UNIT=0 outside REQ/ADDR/READ.
- Latency: minimum miss-to-CMD_VALID = 1 (IDLE) + 1 (REQ, EN already high) + 1 (ADDR) + N + 1 (DONE) cycles.
- EN dropped during ADDR or READ: abort to IDLE the next cycle. REQUEST, ADDRFD and READFD are 0 that cycle; tag_valid stays 0, so the block is re-requested from scratch.
- FLUSH in IDLE: tag_valid <= 0.
- FLUSH during REQ/ADDR/READ/DONE: sets flush_pend. The fill completes, but DONE leaves tag_valid=0 and clears flush_pend, forcing a refetch.
- IP_q changes during a fill: the fill finishes for fill_tag. Hit is re-evaluated in IDLE, and a new miss starts immediately.
- IP wrap (all-ones to 0): no special case; the tag differs, so it is an ordinary miss.
- front_C and FLUSH in the same cycle: both take effect.
- RESET asserted mid-fill: immediate return to reset values, with REQUEST low asynchronously.

Optional Feature:
- Macro: CODE_LOADER_MISS_CNT_EN.
- When defined:
  - Extra output MISS_CNT [15:0], reset 0.
  - Increments by 1 on each IDLE->REQ transition and saturates at 16'hFFFF.
  - Abort-induced re-requests also count.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Cold start, defaults: RESET release, CLK_C toggling, IP=8'h00, EN tied 1, BUSY_SLAVE=0 -> REQUEST rises. ADDRFD pulses with FD_ADDR=8'h00. Exactly 16 READFD beats, then CMD_VALID=1 with COMMAND={beat1,beat0}.
- Hit path: after the fill, IP steps 8'h01..8'h07 -> no REQUEST. COMMAND follows buf[idx] one CLK_B after each CLK_C rise.
- Block crossing: IP=8'h08 -> STALL=1, FD_ADDR=8'h08, new fill. CMD_VALID returns 20 cycles after the miss with EN=1 and no BUSY.
- Backpressure and grant: EN held 0 for 5 cycles, then BUSY_SLAVE=1 on alternate cycles -> REQUEST holds with no ADDRFD until EN. The beat count stays at 16 and data lands in the correct lanes.
- FLUSH mid-READ: FLUSH at beat 7 -> fill completes, CMD_VALID stays 0, a second REQUEST is issued for the same FD_ADDR. EN dropped at beat 3 -> abort and refetch.
- Reset mid-fill: RESET low at beat 5 -> REQUEST, READFD and CMD_VALID go 0 asynchronously. With CODE_LOADER_MISS_CNT_EN, MISS_CNT returns to 0 and then reads 1 after the next miss.
